// File: rtl/alu_arbiter_if.sv
// Requester/response bundle between the issue paths and the ALU arbiter.
// The slave side belongs to the arbiter. The master side belongs to the requesters and the response consumer.
interface alu_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int FW    = 4,
  parameter int SW    = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [FW-1:0]    req0_funct;
  logic             req0_upd;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [FW-1:0]    req1_funct;
  logic             req1_upd;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic [SW-1:0]    rsp_stats;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_funct, req0_upd,
    input  req1_valid, req1_a, req1_b, req1_funct, req1_upd,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_stats,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_funct, req0_upd,
    output req1_valid, req1_a, req1_b, req1_funct, req1_upd,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_stats,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin two-requester sequencer for the shared ALU. It drives the reserve/restore flag controls
// so that operations with upd=0 never disturb the architectural status flags.
module alu_arbiter #(
  parameter int WIDTH = 8,
  parameter int FW    = 4,
  parameter int SW    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [FW-1:0]    o_alu_funct,
  output logic             o_alu_reserve,
  output logic             o_alu_restore,
  input  logic [WIDTH-1:0] i_alu_r,
  input  logic [SW-1:0]    i_alu_stats,
  output logic             o_busy
);

  typedef enum logic [1:0] {IDLE, EXEC, CAP, RESP} state_t;

  state_t           state_q, state_d;
  logic             grant_vld;
  logic             grant_id;
  logic             last_grant_q;
  logic             id_q;
  logic             upd_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [FW-1:0]    funct_q;
  logic [SW-1:0]    stats_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default value first, so no path through the case infers a latch.
  always_comb begin
    state_d        = state_q;
    grant_vld      = 1'b0;
    grant_id       = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    o_alu_reserve  = 1'b0;
    o_alu_restore  = 1'b1;
    case (state_q)
      IDLE: begin
        // On a tie, the requester that was not served last wins.
        grant_vld      = bus.req0_valid | bus.req1_valid;
        grant_id       = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
        bus.req0_ready = grant_vld & ~grant_id;
        bus.req1_ready = grant_vld &  grant_id;
        if (grant_vld) state_d = EXEC;
      end
      EXEC: begin
        o_alu_restore = 1'b0;
        state_d       = CAP;
      end
      CAP: begin
        // Reserve commits the operation's flags. Restore discards them.
        o_alu_reserve = upd_q;
        o_alu_restore = ~upd_q;
        state_d       = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      upd_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      funct_q      <= '0;
      result_q     <= '0;
      stats_q      <= '0;
    end else begin
      if (state_q == IDLE && grant_vld) begin
        last_grant_q <= grant_id;
        id_q         <= grant_id;
        upd_q        <= grant_id ? bus.req1_upd   : bus.req0_upd;
        a_q          <= grant_id ? bus.req1_a     : bus.req0_a;
        b_q          <= grant_id ? bus.req1_b     : bus.req0_b;
        funct_q      <= grant_id ? bus.req1_funct : bus.req0_funct;
      end
      if (state_q == EXEC) result_q <= i_alu_r;
      if (state_q == CAP)  stats_q  <= i_alu_stats;
    end
  end

  assign o_alu_a        = a_q;
  assign o_alu_b        = b_q;
  assign o_alu_funct    = funct_q;
  assign o_busy         = (state_q != IDLE);
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_stats  = stats_q;

endmodule
